// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU run controller.
package cpu_ctrl_pkg;

  localparam logic [2:0] ST_LOAD_ENC = 3'd0;
  localparam logic [2:0] ST_RSTC_ENC = 3'd1;
  localparam logic [2:0] ST_IDLE_ENC = 3'd2;
  localparam logic [2:0] ST_RUN_ENC  = 3'd3;
  localparam logic [2:0] ST_STEP_ENC = 3'd4;

  typedef enum logic [2:0] {
    S_LOAD = ST_LOAD_ENC,
    S_RSTC = ST_RSTC_ENC,
    S_IDLE = ST_IDLE_ENC,
    S_RUN  = ST_RUN_ENC,
    S_STEP = ST_STEP_ENC
  } state_e;

  localparam logic [7:0] NOP_INSN = 8'h00;

  localparam int DEPTH_DEF      = 32;
  localparam int RST_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/prog_mem.sv
// Program memory: byte-wide, synchronous write, asynchronous read.
module prog_mem
  import cpu_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Write port; contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the 8-bit core: program load, core reset, run/step/halt
// gating, pc bound fault and executed-cycle counting.
//
// state | meaning
// ------+---------------------------------------------------------------
// LOAD  | accepting program bytes, core held in reset
// RSTC  | program loaded, core still in reset for RST_CYCLES cycles
// IDLE  | core out of reset, clock enable low, waiting for a command
// RUN   | core free-running until halt or pc fault
// STEP  | core enabled for exactly one cycle
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             origclk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             cmd_load,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic [7:0]       pc,
  output logic [7:0]       instruction,
  output logic             cpu_reset,
  output logic             cpu_clk_en,
  output logic [7:0]       prog_len,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [7:0]       wr_ptr_q, wr_ptr_d;
  logic [7:0]       prog_len_q, prog_len_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic       accept;
  logic       last_byte;
  logic       pc_oob;
  logic [7:0] mem_rdata;

  assign load_ready = (state_q == S_LOAD);
  assign cpu_reset  = (state_q == S_LOAD) || (state_q == S_RSTC);
  assign cpu_clk_en = (state_q == S_RUN) || (state_q == S_STEP);

  assign accept    = load_valid && load_ready;
  assign last_byte = load_last || (wr_ptr_q == 8'(DEPTH - 1));
  assign pc_oob    = (pc >= prog_len_q);

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk_i   (origclk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (pc[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // The address slice is only trusted once pc is known to be inside the program.
  assign instruction = ((state_q != S_LOAD) && !pc_oob) ? mem_rdata : NOP_INSN;

  assign state       = state_q;
  assign prog_len    = prog_len_q;
  assign fault       = fault_q;
  assign cycle_count = cyc_q;

  // Next-state and datapath updates for every controller register.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    rst_cnt_d  = rst_cnt_q;
    fault_d    = fault_q;
    cyc_d      = (cpu_clk_en && (cyc_q != '1)) ? cyc_q + 1'b1 : cyc_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (last_byte) begin
            prog_len_d = wr_ptr_q + 8'd1;
            rst_cnt_d  = RW'(RST_CYCLES - 1);
            fault_d    = 1'b0;
            cyc_d      = '0;
            state_d    = S_RSTC;
          end else begin
            wr_ptr_d = wr_ptr_q + 8'd1;
          end
        end
      end
      S_RSTC: begin
        if (rst_cnt_q == '0) state_d = S_IDLE;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      S_IDLE: begin
        if (cmd_load) begin
          wr_ptr_d = 8'd0;
          state_d  = S_LOAD;
        end else if (!fault_q) begin
          if (cmd_step)     state_d = S_STEP;
          else if (cmd_run) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (pc_oob) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end
        if (cmd_halt) state_d = S_IDLE;
      end
      S_STEP: begin
        if (pc_oob) fault_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Register bank with asynchronous return to the load state.
  always_ff @(posedge origclk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD;
      wr_ptr_q   <= 8'd0;
      prog_len_q <= 8'd0;
      rst_cnt_q  <= '0;
      fault_q    <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      rst_cnt_q  <= rst_cnt_d;
      fault_q    <= fault_d;
      cyc_q      <= cyc_d;
    end
  end

endmodule
